psx_host_poller: RTL and testbench

- Console-side PSX controller port master: the initiator end of the link that the controller emulator answers.
- On a start strobe it asserts SEL, clocks out the standard poll command (0x01, 0x42, 0x00...) and shifts in the response.
- Uses ACK handshakes to pace bytes and decode the response length.
- Stores the response in a 32-byte buffer for readout. Used to drive the emulator on the bench and to poll real pads.

---
 rtl/psx_host_poller.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_psx_host_poller.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psx_host_poller.sv
// ---------------------------------------------------------------------------
// psx_host_poller
//
// Console-side master for a PSX controller port. A start request pulls
// attention (psx_sel) low, clocks out the poll command 0x01, 0x42, 0x00...
// LSB first, and shifts the device reply in on each rising psx_clk edge.
// Device ACK pulses pace the bytes. The ID byte (byte 1) sets how many bytes
// to expect. Captured bytes land in a 32-byte buffer that can be read at any
// time through a registered read port.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   start               one-cycle poll request, honoured only while idle
//   busy                transaction in progress
//   done                one-cycle pulse when a transaction ends
//   no_ack              last transaction ended by an ACK timeout
//   resp_len[5:0]       number of bytes captured by the last transaction
//   rd_addr[4:0]        buffer read address
//   rd_data[7:0]        buffer[rd_addr], one cycle of latency
//   psx_clk             PSX clock, idles high
//   psx_sel             attention, active low
//   psx_cmd             command data to the device, LSB first
//   psx_dat             device data (open collector, pulled up)
//   psx_ack             device acknowledge, active low
// ---------------------------------------------------------------------------
module psx_host_poller #(
  parameter int CLK_DIV     = 96,
  parameter int SEL_SETUP   = 192,
  parameter int ACK_TIMEOUT = 4800,
  parameter int BYTE_GAP    = 96
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       no_ack,
  output logic [5:0] resp_len,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       psx_clk,
  output logic       psx_sel,
  output logic       psx_cmd,
  input  logic       psx_dat,
  input  logic       psx_ack
);

  // One shared down-time counter serves every timed state, so it is sized
  // for the longest interval.
  localparam int MAX_A   = (CLK_DIV > SEL_SETUP) ? CLK_DIV : SEL_SETUP;
  localparam int MAX_B   = (ACK_TIMEOUT > BYTE_GAP) ? ACK_TIMEOUT : BYTE_GAP;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_WAIT_ACK,
    S_GAP,
    S_FINISH
  } state_t;

  // Command byte sent at a given position in the transaction.
  function automatic logic [7:0] cmd_byte(input logic [4:0] idx);
    case (idx)
      5'd0:    return 8'h01;
      5'd1:    return 8'h42;
      default: return 8'h00;
    endcase
  endfunction

  // Expected reply length from the low nibble of the ID byte:
  // 3 header bytes plus n half-words, n=0 meaning 16, capped at the buffer.
  function automatic logic [5:0] len_decode(input logic [3:0] n);
    logic [5:0] n_eff;
    logic [6:0] total;
    n_eff = (n == 4'd0) ? 6'd16 : {2'b00, n};
    total = 7'd3 + {n_eff, 1'b0};
    return (total > 7'd32) ? 6'd32 : total[5:0];
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_lim;
  logic [2:0]       bit_q, bit_d;
  logic [4:0]       byte_idx_q, byte_idx_d;
  logic [5:0]       expected_q, expected_d;
  logic [7:0]       rx_q, rx_d;
  logic [5:0]       resp_len_q, resp_len_d;
  logic             no_ack_q, no_ack_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             clk_q, clk_d;
  logic             sel_q, sel_d;
  logic             cmd_q, cmd_d;
  logic [7:0]       rd_data_q, rd_data_d;

  logic             dat_p0_q, dat_p1_q;
  logic             ack_p0_q, ack_p1_q;

  logic [7:0]       mem [32];
  logic             mem_we;
  logic [4:0]       mem_waddr;
  logic [7:0]       mem_wdata;

  logic             cnt_hit;
  logic             ack_seen;
  logic [5:0]       byte_next;
  logic [5:0]       exp_new;
  logic             last_byte;
  logic [7:0]       cur_cmd;
  logic [2:0]       next_bit;

  // ---- input synchronisers: psx_dat / psx_ack -> *_p1_q ----
  always_ff @(posedge clk) begin
    if (reset) begin
      dat_p0_q <= 1'b1;
      dat_p1_q <= 1'b1;
      ack_p0_q <= 1'b1;
      ack_p1_q <= 1'b1;
    end else begin
      dat_p0_q <= psx_dat;
      dat_p1_q <= dat_p0_q;
      ack_p0_q <= psx_ack;
      ack_p1_q <= ack_p0_q;
    end
  end

  // Terminal count of the current timed state.
  always_comb begin
    cnt_lim = '0;
    case (state_q)
      S_SELECT:              cnt_lim = CNT_W'(SEL_SETUP - 1);
      S_BIT_LOW, S_BIT_HIGH: cnt_lim = CNT_W'(CLK_DIV - 1);
      S_WAIT_ACK:            cnt_lim = CNT_W'(ACK_TIMEOUT - 1);
      S_GAP:                 cnt_lim = CNT_W'(BYTE_GAP - 1);
      default:               cnt_lim = '0;
    endcase
  end

  assign cnt_hit   = (cnt_q == cnt_lim);
  assign ack_seen  = ~ack_p1_q;
  assign byte_next = {1'b0, byte_idx_q} + 6'd1;
  // The ID byte updates the expected length in the same cycle it is stored,
  // so the end-of-transaction test sees the decoded value.
  assign exp_new   = (byte_idx_q == 5'd1) ? len_decode(rx_q[3:0]) : expected_q;
  assign last_byte = (byte_next == exp_new);
  assign cur_cmd   = cmd_byte(byte_idx_q);
  assign next_bit  = bit_q + 3'd1;

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= 3'd0;
      byte_idx_q <= 5'd0;
      expected_q <= 6'd32;
      resp_len_q <= 6'd0;
      no_ack_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      clk_q      <= 1'b1;
      sel_q      <= 1'b1;
      cmd_q      <= 1'b1;
      rd_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      byte_idx_q <= byte_idx_d;
      expected_q <= expected_d;
      resp_len_q <= resp_len_d;
      no_ack_q   <= no_ack_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      clk_q      <= clk_d;
      sel_q      <= sel_d;
      cmd_q      <= cmd_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Shift register and buffer hold data only; they need no reset.
  always_ff @(posedge clk) begin
    rx_q <= rx_d;
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_SELECT;
      S_SELECT:   if (cnt_hit) state_d = S_BIT_LOW;
      S_BIT_LOW:  if (cnt_hit) state_d = S_BIT_HIGH;
      S_BIT_HIGH: begin
        if (cnt_hit) begin
          if (bit_q == 3'd7) begin
            state_d = last_byte ? S_FINISH : S_WAIT_ACK;
          end else begin
            state_d = S_BIT_LOW;
          end
        end
      end
      S_WAIT_ACK: begin
        if (ack_seen) begin
          state_d = S_GAP;
        end else if (cnt_hit) begin
          state_d = S_FINISH;
        end
      end
      S_GAP:      if (cnt_hit) state_d = S_BIT_LOW;
      S_FINISH:   state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // ---- outputs and datapath ----
  always_comb begin
    bit_d      = bit_q;
    byte_idx_d = byte_idx_q;
    expected_d = expected_q;
    rx_d       = rx_q;
    resp_len_d = resp_len_q;
    no_ack_d   = no_ack_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    clk_d      = clk_q;
    sel_d      = sel_q;
    cmd_d      = cmd_q;
    mem_we     = 1'b0;
    mem_waddr  = byte_idx_q;
    mem_wdata  = rx_q;
    rd_data_d  = mem[rd_addr];

    // Every state change restarts the interval counter.
    if ((state_d != state_q) || (state_q == S_IDLE)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sel_d      = 1'b0;
          busy_d     = 1'b1;
          no_ack_d   = 1'b0;
          byte_idx_d = 5'd0;
          resp_len_d = 6'd0;
          expected_d = 6'd32;
        end
      end
      S_SELECT: begin
        if (cnt_hit) begin
          clk_d = 1'b0;
          bit_d = 3'd0;
          cmd_d = cur_cmd[0];
        end
      end
      S_BIT_LOW: begin
        // Data is sampled in the cycle psx_clk rises.
        if (cnt_hit) begin
          clk_d        = 1'b1;
          rx_d[bit_q]  = dat_p1_q;
        end
      end
      S_BIT_HIGH: begin
        if (cnt_hit) begin
          if (bit_q == 3'd7) begin
            mem_we     = 1'b1;
            resp_len_d = byte_next;
            expected_d = exp_new;
            cmd_d      = 1'b1;
            // The final byte gets no ACK wait; release attention right away.
            if (last_byte) begin
              sel_d = 1'b1;
            end
          end else begin
            bit_d = next_bit;
            clk_d = 1'b0;
            cmd_d = cur_cmd[next_bit];
          end
        end
      end
      S_WAIT_ACK: begin
        if (ack_seen) begin
          byte_idx_d = byte_idx_q + 5'd1;
        end else if (cnt_hit) begin
          no_ack_d = 1'b1;
          sel_d    = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_hit) begin
          clk_d = 1'b0;
          bit_d = 3'd0;
          cmd_d = cur_cmd[0];
        end
      end
      S_FINISH: begin
        sel_d  = 1'b1;
        clk_d  = 1'b1;
        cmd_d  = 1'b1;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: begin
        sel_d  = 1'b1;
        clk_d  = 1'b1;
        cmd_d  = 1'b1;
        busy_d = 1'b0;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign no_ack   = no_ack_q;
  assign resp_len = resp_len_q;
  assign rd_data  = rd_data_q;
  assign psx_clk  = clk_q;
  assign psx_sel  = sel_q;
  assign psx_cmd  = cmd_q;

endmodule

// File: tb/tb_psx_host_poller.sv
// ---------------------------------------------------------------------------
// Testbench for psx_host_poller. A cycle-based pad model answers on
// psx_dat/psx_ack, logs the command bytes and edge times; directed tasks run
// one scenario each against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_psx_host_poller;

  logic       clk;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic       no_ack;
  logic [5:0] resp_len;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       psx_clk;
  logic       psx_sel;
  logic       psx_cmd;
  logic       psx_dat;
  logic       psx_ack;

  int n_checks = 0;
  int n_errors = 0;

  // Observer / pad model state
  int         cyc = 0;
  int         done_cnt = 0;
  int         done_t = 0;
  int         sel_fall_t = 0;
  int         last_rise_t = 0;
  int         fall_t [8];
  int         rise_t [8];
  int         m_byte = 0;
  int         m_bit = 0;
  int         m_nack = 0;
  bit         m_present = 1'b0;
  logic [7:0] m_resp [32];
  logic [7:0] cmd_log [32];
  logic       prev_clk = 1'b1;
  logic       prev_sel = 1'b1;

  psx_host_poller dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .no_ack   (no_ack),
    .resp_len (resp_len),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .psx_clk  (psx_clk),
    .psx_sel  (psx_sel),
    .psx_cmd  (psx_cmd),
    .psx_dat  (psx_dat),
    .psx_ack  (psx_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Samples 1 time unit after each rising edge: counts cycles and done
  // pulses, and plays the controller pad (data on falling psx_clk, ACK low
  // for 6 clks starting 100 clks after each acknowledged byte's 8th rise).
  initial begin : observer
    int ack_t;
    logic [7:0] m_sh;
    ack_t = 0;
    m_sh = 8'h00;
    psx_dat = 1'b1;
    psx_ack = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (done === 1'b1) begin
        done_cnt++;
        done_t = cyc;
      end
      if (psx_sel !== 1'b0) begin
        m_byte = 0;
        m_bit = 0;
        ack_t = 0;
        psx_dat = 1'b1;
        psx_ack = 1'b1;
      end else begin
        if (prev_sel) sel_fall_t = cyc;
        if (prev_clk && !psx_clk) begin
          if (m_byte == 0) fall_t[m_bit] = cyc;
          psx_dat = (m_present && m_byte < 32) ? m_resp[m_byte][m_bit] : 1'b1;
        end
        if (!prev_clk && psx_clk) begin
          if (m_byte == 0) rise_t[m_bit] = cyc;
          m_sh[m_bit] = psx_cmd;
          if (m_bit == 7) begin
            last_rise_t = cyc;
            if (m_byte < 32) cmd_log[m_byte] = m_sh;
            if (m_byte < m_nack) ack_t = 1;
            m_byte++;
            m_bit = 0;
          end else begin
            m_bit++;
          end
        end else if (ack_t != 0) begin
          ack_t++;
        end
        psx_ack = !(ack_t >= 100 && ack_t < 106);
        if (ack_t >= 106) ack_t = 0;
      end
      prev_clk = psx_clk;
      prev_sel = psx_sel;
    end
  end

  task automatic set_model(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input int nack,
                           input bit present, input bit patt);
    m_resp[0] = b0;
    m_resp[1] = b1;
    m_resp[2] = b2;
    for (int i = 3; i < 32; i++) m_resp[i] = patt ? 8'(8'h10 + i) : 8'hFF;
    for (int i = 0; i < 32; i++) cmd_log[i] = 8'hXX;
    m_nack = nack;
    m_present = present;
  endtask

  // Issues start for 'hold' clocks, optionally pulses start again 'mid'
  // clocks later, and waits (bounded) for a done pulse.
  task automatic run_poll(input int budget, input int hold, input int mid,
                          output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    @(negedge clk);
    start = 1'b1;
    repeat (hold) @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
      start = (mid != 0 && i == mid);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic rd_buf(input int a, output logic [7:0] v);
    @(negedge clk);
    rd_addr = 5'(a);
    @(posedge clk);
    #1;
    v = rd_data;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    rd_addr = 5'd0;
    repeat (4) @(negedge clk);
    n_checks++; if (psx_clk !== 1'b1) begin n_errors++; $display("FAIL reset_psx_clk got=%b want=1", psx_clk); end
    n_checks++; if (psx_sel !== 1'b1) begin n_errors++; $display("FAIL reset_psx_sel got=%b want=1", psx_sel); end
    n_checks++; if (psx_cmd !== 1'b1) begin n_errors++; $display("FAIL reset_psx_cmd got=%b want=1", psx_cmd); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%b want=0", done); end
    n_checks++; if (no_ack !== 1'b0) begin n_errors++; $display("FAIL reset_no_ack got=%b want=0", no_ack); end
    n_checks++; if (resp_len !== 6'd0) begin n_errors++; $display("FAIL reset_resp_len got=%0d want=0", resp_len); end
    n_checks++; if (rd_data !== 8'h00) begin n_errors++; $display("FAIL reset_rd_data got=%h want=00", rd_data); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int d0;
    set_model(8'hFF, 8'h41, 8'h5A, 4, 1'b1, 1'b0);
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (250) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL midrst_pre_busy got=%b want=1", busy); end
    n_checks++; if (psx_clk !== 1'b0) begin n_errors++; $display("FAIL midrst_pre_clk got=%b want=0", psx_clk); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (psx_sel !== 1'b1) begin n_errors++; $display("FAIL midrst_sel got=%b want=1", psx_sel); end
    n_checks++; if (psx_clk !== 1'b1) begin n_errors++; $display("FAIL midrst_clk got=%b want=1", psx_clk); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy got=%b want=0", busy); end
    n_checks++; if (psx_cmd !== 1'b1) begin n_errors++; $display("FAIL midrst_cmd got=%b want=1", psx_cmd); end
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++; if (done_cnt !== d0) begin n_errors++; $display("FAIL midrst_no_done got=%0d want=%0d", done_cnt, d0); end
  endtask

  task automatic test_digital();
    int d0;
    bit ok;
    logic [7:0] v;
    logic [7:0] exp_cmd [5];
    logic [7:0] exp_buf [5];
    exp_cmd = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};
    exp_buf = '{8'hFF, 8'h41, 8'h5A, 8'hFF, 8'hFF};
    set_model(8'hFF, 8'h41, 8'h5A, 4, 1'b1, 1'b0);
    d0 = done_cnt;
    run_poll(20000, 1, 0, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL dig_done_timeout got=%b want=1", ok); end
    repeat (50) @(negedge clk);
    n_checks++; if (done_cnt - d0 != 1) begin n_errors++; $display("FAIL dig_done_count got=%0d want=1", done_cnt - d0); end
    n_checks++; if (resp_len !== 6'd5) begin n_errors++; $display("FAIL dig_resp_len got=%0d want=5", resp_len); end
    n_checks++; if (no_ack !== 1'b0) begin n_errors++; $display("FAIL dig_no_ack got=%b want=0", no_ack); end
    n_checks++; if (psx_sel !== 1'b1) begin n_errors++; $display("FAIL dig_sel_after got=%b want=1", psx_sel); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL dig_busy_after got=%b want=0", busy); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (cmd_log[i] !== exp_cmd[i]) begin n_errors++; $display("FAIL dig_cmd[%0d] got=%h want=%h", i, cmd_log[i], exp_cmd[i]); end
      rd_buf(i, v);
      n_checks++;
      if (v !== exp_buf[i]) begin n_errors++; $display("FAIL dig_buf[%0d] got=%h want=%h", i, v, exp_buf[i]); end
    end
    n_checks++; if (fall_t[0] - sel_fall_t != 192) begin n_errors++; $display("FAIL wave_sel_setup got=%0d want=192", fall_t[0] - sel_fall_t); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (rise_t[i] - fall_t[i] != 96) begin n_errors++; $display("FAIL wave_low[%0d] got=%0d want=96", i, rise_t[i] - fall_t[i]); end
    end
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (fall_t[i+1] - rise_t[i] != 96) begin n_errors++; $display("FAIL wave_high[%0d] got=%0d want=96", i, fall_t[i+1] - rise_t[i]); end
    end
  endtask

  task automatic test_no_device();
    int d0;
    bit ok;
    logic [7:0] v;
    set_model(8'hFF, 8'hFF, 8'hFF, 0, 1'b0, 1'b0);
    d0 = done_cnt;
    run_poll(20000, 2, 1000, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL nodev_done_timeout got=%b want=1", ok); end
    n_checks++; if (done_t - last_rise_t != 4897) begin n_errors++; $display("FAIL nodev_done_delay got=%0d want=4897", done_t - last_rise_t); end
    repeat (200) @(negedge clk);
    n_checks++; if (done_cnt - d0 != 1) begin n_errors++; $display("FAIL nodev_one_txn got=%0d want=1", done_cnt - d0); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL nodev_busy got=%b want=0", busy); end
    n_checks++; if (no_ack !== 1'b1) begin n_errors++; $display("FAIL nodev_no_ack got=%b want=1", no_ack); end
    n_checks++; if (resp_len !== 6'd1) begin n_errors++; $display("FAIL nodev_resp_len got=%0d want=1", resp_len); end
    n_checks++; if (cmd_log[0] !== 8'h01) begin n_errors++; $display("FAIL nodev_cmd0 got=%h want=01", cmd_log[0]); end
    rd_buf(0, v);
    n_checks++; if (v !== 8'hFF) begin n_errors++; $display("FAIL nodev_buf0 got=%h want=FF", v); end
  endtask

  task automatic test_analog();
    int d0;
    bit ok;
    logic [7:0] v;
    set_model(8'hFF, 8'h73, 8'h5A, 32, 1'b1, 1'b1);
    d0 = done_cnt;
    run_poll(30000, 1, 0, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL ana_done_timeout got=%b want=1", ok); end
    repeat (50) @(negedge clk);
    n_checks++; if (done_cnt - d0 != 1) begin n_errors++; $display("FAIL ana_done_count got=%0d want=1", done_cnt - d0); end
    n_checks++; if (resp_len !== 6'd9) begin n_errors++; $display("FAIL ana_resp_len got=%0d want=9", resp_len); end
    n_checks++; if (no_ack !== 1'b0) begin n_errors++; $display("FAIL ana_no_ack got=%b want=0", no_ack); end
    n_checks++; if (cmd_log[8] !== 8'h00) begin n_errors++; $display("FAIL ana_cmd8 got=%h want=00", cmd_log[8]); end
    rd_buf(1, v);
    n_checks++; if (v !== 8'h73) begin n_errors++; $display("FAIL ana_buf1 got=%h want=73", v); end
    rd_buf(8, v);
    n_checks++; if (v !== 8'h18) begin n_errors++; $display("FAIL ana_buf8 got=%h want=18", v); end
  endtask

  task automatic test_stop_ack();
    int d0;
    bit ok;
    logic [7:0] v;
    set_model(8'hFF, 8'h41, 8'h5A, 2, 1'b1, 1'b1);
    d0 = done_cnt;
    run_poll(30000, 1, 0, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL stop_done_timeout got=%b want=1", ok); end
    repeat (50) @(negedge clk);
    n_checks++; if (done_cnt - d0 != 1) begin n_errors++; $display("FAIL stop_done_count got=%0d want=1", done_cnt - d0); end
    n_checks++; if (no_ack !== 1'b1) begin n_errors++; $display("FAIL stop_no_ack got=%b want=1", no_ack); end
    n_checks++; if (resp_len !== 6'd3) begin n_errors++; $display("FAIL stop_resp_len got=%0d want=3", resp_len); end
    rd_buf(2, v);
    n_checks++; if (v !== 8'h5A) begin n_errors++; $display("FAIL stop_buf2 got=%h want=5A", v); end
  endtask

  task automatic test_long();
    int d0;
    bit ok;
    logic [7:0] v;
    set_model(8'hFF, 8'h40, 8'h5A, 32, 1'b1, 1'b1);
    d0 = done_cnt;
    run_poll(60000, 1, 0, ok);
    n_checks++; if (ok !== 1'b1) begin n_errors++; $display("FAIL long_done_timeout got=%b want=1", ok); end
    repeat (50) @(negedge clk);
    n_checks++; if (done_cnt - d0 != 1) begin n_errors++; $display("FAIL long_done_count got=%0d want=1", done_cnt - d0); end
    n_checks++; if (resp_len !== 6'd32) begin n_errors++; $display("FAIL long_resp_len got=%0d want=32", resp_len); end
    n_checks++; if (no_ack !== 1'b0) begin n_errors++; $display("FAIL long_no_ack got=%b want=0", no_ack); end
    rd_buf(3, v);
    n_checks++; if (v !== 8'h13) begin n_errors++; $display("FAIL long_buf3 got=%h want=13", v); end
    rd_buf(31, v);
    n_checks++; if (v !== 8'h2F) begin n_errors++; $display("FAIL long_buf31 got=%h want=2F", v); end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    rd_addr = 5'd0;
    test_reset();
    test_reset_mid();
    test_digital();
    test_no_device();
    test_analog();
    test_stop_ack();
    test_long();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
